// File: rtl/monolith_perm_ctrl.sv
// Round sequencer for a Monolith permutation: loads a state, runs one concrete-only
// pre-round plus NUM_ROUNDS full rounds through an external round datapath, then presents the result.
module monolith_perm_ctrl #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16,
    parameter int NUM_ROUNDS = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [STATE_SIZE*WORD_WIDTH-1:0] in_state,
    output logic [2:0]                       rc_idx,
    input  logic [STATE_SIZE*WORD_WIDTH-1:0] rc_data,
    output logic                             rnd_load,
    output logic                             rnd_pre_round,
    output logic [STATE_SIZE*WORD_WIDTH-1:0] rnd_state,
    output logic [STATE_SIZE*WORD_WIDTH-1:0] rnd_constants,
    input  logic [STATE_SIZE*WORD_WIDTH-1:0] rnd_result,
    input  logic                             rnd_valid,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [STATE_SIZE*WORD_WIDTH-1:0] out_state
);

    localparam int SW = STATE_SIZE * WORD_WIDTH;
    localparam logic [2:0] LAST_ROUND = 3'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUTPUT} fsm_t;

    fsm_t            state, state_next;
    logic [SW-1:0]   state_reg;
    logic [2:0]      counter;
    logic            pre;
    logic            last_round;

    assign last_round = (counter == LAST_ROUND);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (in_valid) state_next = LOAD;
            LOAD:   state_next = WAIT;
            WAIT: begin
                if (rnd_valid) begin
                    if (!pre && last_round) state_next = OUTPUT;
                    else                    state_next = LOAD;
                end
            end
            OUTPUT: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= '0;
            counter   <= '0;
            pre       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_state;
                        counter   <= '0;
                        pre       <= 1'b1;
                    end
                end
                WAIT: begin
                    if (rnd_valid) begin
                        state_reg <= rnd_result;
                        // the pre-round does not consume a round-counter step
                        if (pre)              pre     <= 1'b0;
                        else if (!last_round) counter <= counter + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready      = (state == IDLE) && !reset;
        out_valid     = (state == OUTPUT) && !reset;
        rnd_load      = reset || (state == LOAD);
        rnd_constants = (pre || last_round) ? '0 : rc_data;
    end

    assign rc_idx        = counter;
    assign rnd_pre_round = pre;
    assign rnd_state     = state_reg;
    assign out_state     = state_reg;

endmodule

// File: doc/monolith_perm_ctrl.md
MONOLITH_PERM_CTRL -- requirements
Module: monolith_perm_ctrl

Interface
REQ-001 Parameter WORD_WIDTH, 31, field element width in bits.
REQ-002 Parameter STATE_SIZE, 16, state words per permutation.
REQ-003 Parameter NUM_ROUNDS, 6, full rounds after the concrete-only pre-round; legal range 1..8.
REQ-004 clk  input  1  clock; all state SHALL update on posedge clk only.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream offers a state.
REQ-007 in_ready  output  1  controller accepts a state.
REQ-008 in_state  input  STATE_SIZE x WORD_WIDTH  permutation input.
REQ-009 rc_idx  output  3  round-constant ROM address, equal to the round counter.
REQ-010 rc_data  input  STATE_SIZE x WORD_WIDTH  ROM data; combinational, valid in the same cycle as rc_idx.
REQ-011 rnd_load  output  1  drives the round datapath's reset pin; high loads the round's input registers.
REQ-012 rnd_pre_round  output  1  pre-round select to the round datapath.
REQ-013 rnd_state  output  STATE_SIZE x WORD_WIDTH  state to the round datapath, driven from the internal state register.
REQ-014 rnd_constants  output  STATE_SIZE x WORD_WIDTH  round constants to the round datapath.
REQ-015 rnd_result  input  STATE_SIZE x WORD_WIDTH  round datapath output.
REQ-016 rnd_valid  input  1  round datapath result valid.
REQ-017 out_valid  output  1  permutation result available.
REQ-018 out_ready  input  1  downstream accepts the result.
REQ-019 out_state  output  STATE_SIZE x WORD_WIDTH  permutation result, equal to the internal state register.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, WAIT and OUTPUT; in_ready SHALL be high only in IDLE, and out_valid SHALL be high only in OUTPUT.
REQ-021 IDLE with in_valid=1 SHALL capture in_state into the state register, clear the counter, set the pre flag, and go to LOAD; otherwise the FSM stays in IDLE.
REQ-022 LOAD SHALL last exactly one cycle with rnd_load=1, then go to WAIT.
REQ-023 rnd_load SHALL be the combinational value (reset OR state==LOAD).
REQ-024 rnd_pre_round SHALL equal the pre flag.
REQ-025 rnd_constants SHALL be all-zero when the pre flag is set or counter==NUM_ROUNDS-1; otherwise it SHALL equal rc_data.
REQ-026 WAIT with rnd_valid=1 SHALL capture rnd_result into the state register.
REQ-027 Branch on that same edge: if the pre flag is set, clear it and go to LOAD; else if counter==NUM_ROUNDS-1, go to OUTPUT; else increment the counter and go to LOAD.
REQ-028 rnd_valid SHALL be ignored in every state except WAIT; WAIT with rnd_valid=0 SHALL hold.
REQ-029 OUTPUT SHALL hold out_state stable until out_ready=1, then go to IDLE; back-to-back acceptance SHALL be possible on the following cycle.
REQ-030 Total latency SHALL be (NUM_ROUNDS+1) LOAD cycles plus the sum of the WAIT durations, plus one cycle into OUTPUT.
REQ-031 in_valid asserted while not in IDLE SHALL have no effect.
REQ-032 Each permutation SHALL issue exactly NUM_ROUNDS+1 LOAD pulses: one pre-round, then rounds with counter 0..NUM_ROUNDS-1.

Reset
REQ-033 Reset SHALL force IDLE, counter=0, pre flag=0, state register=0, out_valid=0 and in_ready=0 while asserted; rnd_load SHALL be 1 while reset is asserted.
REQ-034 Reset asserted mid-permutation SHALL abort the permutation with no out_valid; in_ready=1 on the first cycle after deassertion.

Verification
REQ-035 Single permutation, NUM_ROUNDS=6, round model with fixed 4-cycle latency, in_state all 1, out_ready=1: 7 LOAD pulses; rnd_pre_round=1 only on the first; rc_idx 0,0,1,2,3,4,5; rnd_constants zero on the first and last pulse; out_state equals the golden Monolith-31 result.
REQ-036 Backpressure: out_ready=0 for 10 cycles -> out_valid held, out_state constant, in_ready=0; a new in_valid is ignored.
REQ-037 Spurious rnd_valid=1 during IDLE, LOAD and OUTPUT -> no state-register change and no FSM transition.
REQ-038 Reset pulsed in WAIT of round 3 -> no out_valid; the next permutation with in_state=0 produces the golden result for zero input.
REQ-039 Back-to-back: in_valid held high across two inputs -> second accepted on the cycle after the first out_valid/out_ready handshake; both results correct.
REQ-040 Random round latency of 1..20 cycles per round -> results match the golden model over 1000 permutations.
